// File: rtl/ez8_prog_loader.sv
// ============================================================================
// ez8_prog_loader : serial frame loader for the EZ8 instruction memory
// Optional inter-byte timeout enabled by macro EZ8_LOADER_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ez8_prog_loader #(
   parameter int unsigned RESET_HOLD     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [11:0] instr_writeaddr,
   output logic [15:0] instr_writedata,
   output logic        instr_write_en,
   output logic        cpu_pause,
   output logic        cpu_hold,
   output logic        busy,
   output logic        error
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LEN_HI  = 3'd1,
      S_LEN_LO  = 3'd2,
      S_DATA_HI = 3'd3,
      S_DATA_LO = 3'd4,
      S_CHECK   = 3'd5,
      S_DONE    = 3'd6,
      S_ERROR   = 3'd7
   } state_t;

   localparam logic [7:0]  c_HOLD_LAST = 8'(RESET_HOLD - 1);
   localparam logic [23:0] c_TMO       = 24'(TIMEOUT_CYCLES);

   state_t      r_state, w_next;
   logic [7:0]  r_len_hi, r_data_hi, r_csum, r_hold;
   logic [12:0] r_len, r_words;
   logic [11:0] r_addr, r_waddr;
   logic [15:0] r_wdata, w_len;
   logic        r_error, r_we;
   logic        w_accept, w_sync, w_len_bad, w_last_word, w_timeout;

   assign rx_ready    = (r_state != S_DONE);
   assign w_accept    = rx_valid & rx_ready;
   assign w_sync      = w_accept & (rx_data == 8'hA5);
   assign w_len       = {r_len_hi, rx_data};
   assign w_len_bad   = (w_len == 16'd0) || (w_len > 16'd4096);
   assign w_last_word = ((r_words + 13'd1) == r_len);

`ifdef EZ8_LOADER_TIMEOUT_EN
   logic [23:0] r_tmo;
   logic        w_timed;

   assign w_timed   = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                      (r_state == S_DATA_HI) || (r_state == S_DATA_LO) ||
                      (r_state == S_CHECK);
   assign w_timeout = w_timed & ~w_accept & (r_tmo == (c_TMO - 24'd1));

   always_ff @(posedge clk) begin
      if (reset || !w_timed || w_accept) r_tmo <= 24'd0;
      else                               r_tmo <= r_tmo + 24'd1;
   end
`else
   logic w_unused_tmo;
   assign w_unused_tmo = ^c_TMO;
   assign w_timeout    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_ERROR: if (w_sync)   w_next = S_LEN_HI;
         S_LEN_HI:        if (w_accept) w_next = S_LEN_LO;
         S_LEN_LO:        if (w_accept) w_next = w_len_bad ? S_ERROR : S_DATA_HI;
         S_DATA_HI:       if (w_accept) w_next = S_DATA_LO;
         S_DATA_LO:       if (w_accept) w_next = w_last_word ? S_CHECK : S_DATA_HI;
         S_CHECK:         if (w_accept) w_next = (rx_data == r_csum) ? S_DONE : S_ERROR;
         S_DONE:          if (r_hold == 8'd0) w_next = S_IDLE;
         default:         w_next = S_IDLE;
      endcase
      if (w_timeout) w_next = S_ERROR;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_len_hi  <= 8'd0;
         r_data_hi <= 8'd0;
         r_csum    <= 8'd0;
         r_hold    <= 8'd0;
         r_len     <= 13'd0;
         r_words   <= 13'd0;
         r_addr    <= 12'd0;
         r_waddr   <= 12'd0;
         r_wdata   <= 16'd0;
         r_error   <= 1'b0;
         r_we      <= 1'b0;
      end else begin
         r_we <= 1'b0;
         case (r_state)
            S_IDLE, S_ERROR: if (w_sync) begin
               r_error <= 1'b0;
               r_addr  <= 12'd0;
               r_csum  <= 8'd0;
               r_words <= 13'd0;
            end
            S_LEN_HI:  if (w_accept) r_len_hi <= rx_data;
            S_LEN_LO:  if (w_accept) r_len <= w_len[12:0];
            S_DATA_HI: if (w_accept) begin
               r_data_hi <= rx_data;
               r_csum    <= r_csum + rx_data;
            end
            S_DATA_LO: if (w_accept) begin
               r_we    <= 1'b1;
               r_wdata <= {r_data_hi, rx_data};
               r_waddr <= r_addr;
               r_addr  <= r_addr + 12'd1;
               r_words <= r_words + 13'd1;
               r_csum  <= r_csum + rx_data;
            end
            S_CHECK:   if (w_accept) r_hold <= c_HOLD_LAST;
            S_DONE:    if (r_hold != 8'd0) r_hold <= r_hold - 8'd1;
            default:   ;
         endcase
         // Every path into ERROR (bad length, bad checksum, timeout) flags it here.
         if (w_next == S_ERROR) r_error <= 1'b1;
      end
   end

   assign instr_write_en  = r_we;
   assign instr_writeaddr = r_waddr;
   assign instr_writedata = r_wdata;
   assign cpu_pause       = (r_state != S_IDLE);
   assign cpu_hold        = (r_state != S_IDLE);
   assign busy            = (r_state != S_IDLE) && (r_state != S_ERROR);
   assign error           = r_error;

endmodule

`default_nettype wire

// File: tb/tb_ez8_prog_loader.sv
// ============================================================================
// tb_ez8_prog_loader : randomized frame bench with a frame-level reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ez8_prog_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [11:0] instr_writeaddr;
   logic [15:0] instr_writedata;
   logic        instr_write_en;
   logic        cpu_pause, cpu_hold, busy, error;

   int n_checks = 0;
   int n_errors = 0;
   int gap_max  = 2;
   int n_double = 0;
   bit prev_we  = 1'b0;
   bit exp_err  = 1'b0;

   logic [15:0] words [0:4095];
   logic [11:0] got_addr [$];
   logic [15:0] got_data [$];

   ez8_prog_loader #(.RESET_HOLD(16), .TIMEOUT_CYCLES(100)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .instr_writeaddr(instr_writeaddr),
      .instr_writedata(instr_writedata), .instr_write_en(instr_write_en),
      .cpu_pause(cpu_pause), .cpu_hold(cpu_hold), .busy(busy), .error(error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (instr_write_en) begin
         got_addr.push_back(instr_writeaddr);
         got_data.push_back(instr_writedata);
         if (prev_we) n_double++;
      end
      prev_we = instr_write_en;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t;
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      t = 0;
      while (!rx_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (!rx_ready) check_val("rx_ready_wait", 32'(rx_ready), 32'd1);
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic do_reset();
      rx_valid = 1'b0;
      reset    = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset    = 1'b0;
      exp_err  = 1'b0;
   endtask

   task automatic clear_writes();
      got_addr.delete();
      got_data.delete();
   endtask

   // Sends a whole frame built from words[0..n-1]; bad picks a wrong checksum.
   task automatic run_frame(input int n, input bit bad);
      int          sum;
      int          h;
      logic [7:0]  csum;
      logic [15:0] len;
      sum = 0;
      for (int i = 0; i < n; i++) sum += int'(words[i][15:8]) + int'(words[i][7:0]);
      csum = 8'(sum % 256);
      if (bad) csum = csum ^ 8'($urandom_range(1, 255));
      len = 16'(n);
      clear_writes();
      send_byte(8'hA5);
      send_byte(len[15:8]);
      send_byte(len[7:0]);
      check_val("busy_in_frame", 32'(busy), 32'd1);
      check_val("pause_in_frame", 32'(cpu_pause), 32'd1);
      for (int i = 0; i < n; i++) begin
         send_byte(words[i][15:8]);
         send_byte(words[i][7:0]);
      end
      send_byte(csum);
      check_val("write_count", 32'(got_addr.size()), 32'(n));
      for (int i = 0; i < n && i < got_addr.size(); i++) begin
         check_val("write_addr", 32'(got_addr[i]), 32'(i % 4096));
         check_val("write_data", 32'(got_data[i]), 32'(words[i]));
      end
      if (!bad) begin
         check_val("done_rx_ready", 32'(rx_ready), 32'd0);
         check_val("done_busy", 32'(busy), 32'd1);
         h = 0;
         while (cpu_hold && h < 1000) begin
            h++;
            @(posedge clk);
            #1;
         end
         check_val("hold_cycles", 32'(h), 32'd16);
         check_val("idle_pause", 32'(cpu_pause), 32'd0);
         check_val("idle_error", 32'(error), 32'd0);
         check_val("idle_busy", 32'(busy), 32'd0);
      end else begin
         check_val("bad_csum_error", 32'(error), 32'd1);
         check_val("bad_csum_hold", 32'(cpu_hold), 32'd1);
         check_val("bad_csum_busy", 32'(busy), 32'd0);
      end
      exp_err = bad;
   endtask

   task automatic bad_len(input logic [7:0] hi, input logic [7:0] lo);
      clear_writes();
      send_byte(8'hA5);
      send_byte(hi);
      send_byte(lo);
      repeat (3) @(posedge clk);
      #1;
      check_val("badlen_error", 32'(error), 32'd1);
      check_val("badlen_hold", 32'(cpu_hold), 32'd1);
      check_val("badlen_busy", 32'(busy), 32'd0);
      check_val("badlen_writes", 32'(got_addr.size()), 32'd0);
      exp_err = 1'b1;
   endtask

   task automatic send_junk(input int cnt);
      logic [7:0] b;
      for (int i = 0; i < cnt; i++) begin
         b = 8'($urandom_range(0, 255));
         if (b == 8'hA5) b = 8'h5A;
         send_byte(b);
      end
   endtask

   initial begin
      logic [7:0] junk [0:2];
      do_reset();
      check_val("rst_rx_ready", 32'(rx_ready), 32'd1);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_error", 32'(error), 32'd0);
      check_val("rst_pause", 32'(cpu_pause), 32'd0);
      check_val("rst_hold", 32'(cpu_hold), 32'd0);
      check_val("rst_we", 32'(instr_write_en), 32'd0);
      check_val("rst_addr", 32'(instr_writeaddr), 32'd0);
      check_val("rst_data", 32'(instr_writedata), 32'd0);

      junk[0] = 8'h00; junk[1] = 8'hFF; junk[2] = 8'h3C;
      for (int i = 0; i < 3; i++) send_byte(junk[i]);
      check_val("junk_pause", 32'(cpu_pause), 32'd0);
      check_val("junk_busy", 32'(busy), 32'd0);

      words[0] = 16'h1234; words[1] = 16'hABCD;
      run_frame(2, 1'b0);
      clear_writes();
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
      send_byte(8'h00);
      check_val("zero_csum_writes", 32'(got_addr.size()), 32'd2);
      check_val("zero_csum_error", 32'(error), 32'd1);
      check_val("zero_csum_hold", 32'(cpu_hold), 32'd1);
      run_frame(2, 1'b0);

      bad_len(8'h00, 8'h00);
      bad_len(8'h10, 8'h01);

      for (int it = 0; it < 20; it++) begin
         int n;
         bit bad;
         send_junk($urandom_range(0, 3));
         check_val("junk_err_kept", 32'(error), 32'(exp_err));
         check_val("junk_hold", 32'(cpu_hold), 32'(exp_err));
         n   = $urandom_range(1, 12);
         bad = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < n; i++)
            words[i] = ($urandom_range(0, 3) == 0) ? 16'hA5A5 : 16'($urandom);
         run_frame(n, bad);
      end

      gap_max = 0;
      for (int i = 0; i < 4096; i++) words[i] = 16'($urandom);
      run_frame(4096, 1'b0);
      if (got_addr.size() == 4096) check_val("last_addr", 32'(got_addr[4095]), 32'hFFF);
      gap_max = 2;

      clear_writes();
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h03);
      send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_val("midrst_busy", 32'(busy), 32'd0);
      check_val("midrst_hold", 32'(cpu_hold), 32'd0);
      check_val("midrst_error", 32'(error), 32'd0);
      check_val("midrst_addr", 32'(instr_writeaddr), 32'd0);
      check_val("midrst_data", 32'(instr_writedata), 32'd0);
      send_byte(8'h78); send_byte(8'h9A);
      repeat (10) @(posedge clk);
      #1;
      check_val("midrst_writes", 32'(got_addr.size()), 32'd1);
      if (got_data.size() > 0) check_val("midrst_word", 32'(got_data[0]), 32'h1234);

      do_reset();
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
`ifdef EZ8_LOADER_TIMEOUT_EN
      begin
         int t;
         t = 0;
         while (!error && t < 150) begin
            @(negedge clk);
            t++;
         end
         check_val("tmo_error", 32'(error), 32'd1);
         check_val("tmo_within", 32'(t <= 100), 32'd1);
      end
`else
      repeat (1000) @(posedge clk);
      #1;
      check_val("stall_error", 32'(error), 32'd0);
      check_val("stall_busy", 32'(busy), 32'd1);
`endif
      do_reset();

      check_val("double_strobe", 32'(n_double), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ez8_prog_loader.md
EZ8_PROG_LOADER -- requirements
Module: ez8_prog_loader

Interface
REQ-001 Parameter RESET_HOLD, default 16: cycles cpu_hold stays high after a successful load (range 1..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 5000000: maximum gap between accepted bytes inside a frame (24-bit).
REQ-003 Port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port rx_data, input, 8: byte from the serial receiver.
REQ-006 Port rx_valid, input, 1: rx_data valid this cycle.
REQ-007 Port rx_ready, output, 1: loader accepts rx_data this cycle; a byte transfers when rx_valid and rx_ready are both high.
REQ-008 Port instr_writeaddr, output, 12: instruction memory write address.
REQ-009 Port instr_writedata, output, 16: instruction memory write data.
REQ-010 Port instr_write_en, output, 1: one-cycle write strobe.
REQ-011 Port cpu_pause, output, 1: stalls the CPU.
REQ-012 Port cpu_hold, output, 1: holds the CPU in reset; top level ORs it with the board reset.
REQ-013 Port busy, output, 1: a frame is in progress.
REQ-014 Port error, output, 1: last frame failed; sticky.

Function
REQ-015 Frame format: 0xA5, LEN_HI, LEN_LO, then LEN words of 2 bytes each (high byte first), then CSUM; CSUM is the 8-bit modulo-256 sum of all data bytes.
REQ-016 States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR.
REQ-017 IDLE: bytes other than 0xA5 are accepted and discarded. On 0xA5, go to LEN_HI, clear error, set address to 0 and checksum to 0.
REQ-018 ERROR: same handling as IDLE, except that error stays 1 until a 0xA5 is accepted.
REQ-019 LEN_LO: LEN = {LEN_HI, LEN_LO}. If LEN is 0 or greater than 4096, go to ERROR; otherwise go to DATA_HI.
REQ-020 DATA_HI: latch the byte and go to DATA_LO.
REQ-021 DATA_LO: on acceptance, instr_write_en is high for exactly the next cycle, with instr_writedata = {hi, lo} and instr_writeaddr = current address.
REQ-022 After each write the address increments by 1 (word 4096 is written at address 0xFFF with no wrap).
REQ-023 After word LEN, go to CHECK; otherwise go back to DATA_HI.
REQ-024 CHECK: if the received byte equals the checksum, go to DONE; otherwise go to ERROR.
REQ-025 DONE: cpu_hold stays high for RESET_HOLD cycles, then the block goes to IDLE with cpu_hold=0 and cpu_pause=0.
REQ-026 rx_ready is 1 in every state except DONE.
REQ-027 cpu_pause and cpu_hold are 1 in every state except IDLE, starting the cycle after the 0xA5 is accepted.
REQ-028 busy is 1 in LEN_HI through DONE.
REQ-029 A 0xA5 byte received inside a frame is treated as data/length/checksum, never as a restart.
REQ-030 instr_write_en is never high outside the cycle defined in REQ-021.

Reset
REQ-031 While reset is high, on the following edge: state becomes IDLE, error=0, busy=0, cpu_pause=0, cpu_hold=0, instr_write_en=0, instr_writeaddr=0, instr_writedata=0, rx_ready=1, checksum=0.
REQ-032 A reset mid-frame aborts the frame, issues no further writes, and leaves already-written words unchanged.

Configuration
REQ-033 Macro EZ8_LOADER_TIMEOUT_EN defined: in states LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK, a counter reloads on each accepted byte.
REQ-034 With EZ8_LOADER_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES cycles without an accepted byte moves the block to ERROR.
REQ-035 With EZ8_LOADER_TIMEOUT_EN undefined, there is no counter and the block waits indefinitely in every state.

Verification
REQ-036 Frame A5 00 02 12 34 AB CD BE -> writes (0x000, 0x1234) then (0x001, 0xABCD), each one cycle; no error; cpu_hold high for 16 cycles after CHECK, then IDLE with pause/hold at 0.
REQ-037 Same frame with CSUM=0x00 -> two writes, then error=1 and cpu_hold stays 1; a following valid frame clears error and releases the CPU.
REQ-038 A5 00 00, and separately A5 10 01 -> ERROR with no writes; LEN=4096 frame -> last write at 0xFFF.
REQ-039 Bytes 00 FF 3C in IDLE -> ignored, no state change, CPU stays running.
REQ-040 Reset asserted after the 3rd data byte -> IDLE, all outputs at reset values, no further write strobes.
REQ-041 With EZ8_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=100, a stall after LEN_LO -> error=1 within 100 cycles; with the macro undefined, the same stall gives no error after 1000 cycles.
